// File: rtl/counter_param_updown.sv
// rtl/counter_param_updown.sv - parametrised up/down counter with wrap/saturate, clear, load and terminal flags
// Optional cycle prescaler on the step enable when COUNTER_PRESCALE_EN is defined.
module counter_param_updown #(
   parameter int                WIDTH    = 8,
   parameter longint unsigned   MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
   parameter int                SATURATE = 0,
   parameter int                PRESCALE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             count_enb,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up_dn,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf_sticky,
   output logic             at_max,
   output logic             at_min
);

   localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
   localparam bit               SAT   = (SATURATE != 0);

   logic             step;
   logic [WIDTH-1:0] count_nxt;
   logic             tc_nxt;
   logic             ovf_nxt;

`ifdef COUNTER_PRESCALE_EN
   localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre;

   assign step = count_enb && (pre == PRE_LAST);

   // Prescaler restarts its period on clear/load so a load never inherits a partial period.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre <= '0;
      end else if (clear || load) begin
         pre <= '0;
      end else if (count_enb) begin
         pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
      end
   end
`else
   logic unused_prescale;
   assign unused_prescale = (PRESCALE >= 1);
   assign step = count_enb;
`endif

   always_comb begin
      count_nxt = count;
      tc_nxt    = 1'b0;
      ovf_nxt   = ovf_sticky;
      if (clear) begin
         count_nxt = '0;
         ovf_nxt   = 1'b0;
      end else if (load) begin
         count_nxt = (load_val > MAX_W) ? MAX_W : load_val;
      end else if (step) begin
         if (up_dn) begin
            if (count == MAX_W) begin
               tc_nxt    = 1'b1;
               ovf_nxt   = 1'b1;
               count_nxt = SAT ? MAX_W : '0;
            end else begin
               count_nxt = count + 1'b1;
            end
         end else begin
            if (count == '0) begin
               tc_nxt    = 1'b1;
               ovf_nxt   = 1'b1;
               count_nxt = SAT ? '0 : MAX_W;
            end else begin
               count_nxt = count - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count      <= '0;
         tc         <= 1'b0;
         ovf_sticky <= 1'b0;
      end else begin
         count      <= count_nxt;
         tc         <= tc_nxt;
         ovf_sticky <= ovf_nxt;
      end
   end

   assign at_max = (count == MAX_W);
   assign at_min = (count == '0);

endmodule

// File: doc/counter_param_updown.md
Name: counter_param_updown

Overview:
- Parametrised up/down counter. Next generation of the team's 8-bit enable counter.
- Adds configurable width and modulus, wrap or saturate mode, synchronous clear, parallel load, and direction control.
- Adds registered terminal-event and sticky overflow flags.
- Used as a general event/timebase counter in control paths; purely synchronous datapath apart from the async reset.

Parameters:
- WIDTH, 8, counter width in bits (legal: 1..32).
- MAX_VAL, 2**WIDTH-1, upper bound of count range 0..MAX_VAL (legal: 1..2**WIDTH-1).
- SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds.
- PRESCALE, 4, enabled cycles per count step; used only when COUNTER_PRESCALE_EN is defined (legal: >=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- count_enb  input  1  count enable; a step is taken only while high.
- clear  input  1  synchronous clear; highest priority.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value captured on load.
- up_dn  input  1  direction: 1 = up, 0 = down.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-event pulse, registered, one cycle wide.
- ovf_sticky  output  1  sticky terminal-event flag.
- at_max  output  1  combinational: count == MAX_VAL.
- at_min  output  1  combinational: count == 0.

Behaviour:
- Reset: reset is asynchronous, active-low; clock is clk. While reset = 0: count = 0, tc = 0, ovf_sticky = 0, prescaler = 0. Reset may assert mid-operation; every state element clears immediately, with no partial update. First step is possible on the first rising edge after reset deasserts.
- Per-edge priority:
  1. clear: count <= 0, ovf_sticky <= 0, tc <= 0.
  2. load: count <= min(load_val, MAX_VAL); tc <= 0; ovf_sticky unchanged.
  3. step (see below).
  4. Otherwise hold; tc <= 0.
- step = count_enb, or the prescaler tick when COUNTER_PRESCALE_EN is defined.
- Up step:
  - count < MAX_VAL: count + 1.
  - count == MAX_VAL, SATURATE = 0: count <= 0, tc <= 1, ovf_sticky <= 1.
  - count == MAX_VAL, SATURATE = 1: count holds, tc <= 1, ovf_sticky <= 1.
- Down step:
  - count > 0: count - 1.
  - count == 0, SATURATE = 0: count <= MAX_VAL, tc <= 1, ovf_sticky <= 1.
  - count == 0, SATURATE = 1: count holds, tc <= 1, ovf_sticky <= 1.
- tc timing: high in exactly the cycle following the edge that performed the terminal step. In saturate mode with the enable held at a bound, tc stays high on every blocked step.
- Arithmetic is WIDTH bits, with no intermediate overflow. When MAX_VAL < 2**WIDTH-1, count never leaves 0..MAX_VAL by any path.
- up_dn may change on any cycle; it is sampled at the same edge as the step.
- Simultaneous events:
  - clear with load or step: clear wins.
  - load with step: load wins; no step is taken that cycle.
- at_max / at_min are decoded from the count register; there is no extra latency.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- Defined: an internal prescaler counts cycles with count_enb = 1, range 0..PRESCALE-1.
  - A step occurs only on a cycle with count_enb = 1 and prescaler == PRESCALE-1; the prescaler then wraps to 0.
  - The prescaler holds while count_enb = 0.
  - The prescaler clears on reset, clear and load.
  - PRESCALE = 1 behaves identically to the macro-undefined build.
- Undefined: no prescaler logic; every cycle with count_enb = 1 is a step. The PRESCALE parameter is ignored.

Test Plan (WIDTH=8, MAX_VAL=9, SATURATE=0 unless stated):
- Reset then up_dn=1, count_enb=1 for 12 cycles -> count 1..9, 0, 1, 2. tc high only in the cycle after 9->0; ovf_sticky=1 from then on.
- From count=0: up_dn=0, one step -> count=9, tc pulse, ovf_sticky=1. Then clear=1 -> count=0, ovf_sticky=0.
- SATURATE=1, count=9, up_dn=1, enable for 3 cycles -> count stays 9, tc high for 3 cycles, at_max=1. Repeat at 0 going down -> stays 0, at_min=1.
- load_val=200 with load=1 -> count=9 (clamped). Same edge with clear=1 -> count=0. load together with count_enb -> loaded value, no increment.
- Assert reset low asynchronously mid-count at count=5 -> count=0, tc=0, ovf_sticky=0 before the next clk edge. Counting resumes 1, 2, ... after release.
- COUNTER_PRESCALE_EN defined, PRESCALE=4, count_enb=1 for 16 cycles -> count 0 to 4, one step every 4th enabled cycle. Dropping count_enb for 2 cycles mid-period delays the next step by exactly 2 cycles.
